// File: rtl/div3_seq.sv
// Sequential unsigned divide-by-3: one radix-2 restoring step per clock, MSB first,
// valid/ready on both sides. Define DIV3_ROUND_EN for a round-to-nearest quotient.
module div3_seq #(
    parameter int IN_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IN_W-1:0] quot,
    output logic [1:0]      rem
);

    localparam int CNT_W = (IN_W > 2) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One restoring step: returns {q_bit, next_remainder}; t never exceeds 5.
    function automatic logic [2:0] div3_step(input logic [1:0] r, input logic b);
        logic [2:0] t;
        logic [2:0] d;
        t = {r, b};
        d = t - 3'd3;
        if (t >= 3'd3) begin
            return {1'b1, d[1:0]};
        end else begin
            return {1'b0, t[1:0]};
        end
    endfunction

    state_t            state_r;
    logic [IN_W-1:0]   dvd_r;      // dividend bits shift out, quotient bits shift in
    logic [1:0]        r_r;
    logic [CNT_W-1:0]  count_r;
    logic [IN_W-1:0]   quot_r;
    logic [1:0]        rem_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [2:0]        step_s;
    logic [IN_W-1:0]   shifted_s;

    // Current restoring step applied to the partial remainder and dividend MSB.
    always_comb begin
        step_s    = div3_step(r_r, dvd_r[IN_W-1]);
        shifted_s = {dvd_r[IN_W-2:0], step_s[2]};
    end

    // Handshake FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            dvd_r       <= '0;
            r_r         <= 2'd0;
            count_r     <= CNT_ZERO;
            quot_r      <= '0;
            rem_r       <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        dvd_r      <= in_data;
                        r_r        <= 2'd0;
                        count_r    <= CNT_LAST;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_BUSY;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    dvd_r <= shifted_s;
                    r_r   <= step_s[1:0];
                    if (count_r == CNT_ZERO) begin
                        quot_r      <= shifted_s;
                        rem_r       <= step_s[1:0];
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        count_r <= count_r - CNT_ONE;
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign rem       = rem_r;

`ifdef DIV3_ROUND_EN
    // A remainder of 2 means dividend/3 is closer to the next integer.
    assign quot = quot_r + {{(IN_W-1){1'b0}}, (rem_r == 2'd2)};
`else
    assign quot = quot_r;
`endif

endmodule

// File: tb/tb_div3_seq.sv
// Scoreboard bench for div3_seq: directed cases, backpressure, mid-busy reset and
// a randomly stalled 0..2^IN_W-1 sweep checked against plain integer division.
module tb_div3_seq;

    localparam int IN_W = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IN_W-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [IN_W-1:0] quot;
    logic [1:0]      rem;

    typedef struct {
        int d;
        int q;
        int r;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   sweep_done = 1'b0;

    div3_seq #(.IN_W(IN_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .quot(quot), .rem(rem)
    );

    always #5 clk = ~clk;

    function automatic int model_q(input int d);
`ifdef DIV3_ROUND_EN
        return (d + 1) / 3;
`else
        return d / 3;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = IN_W'(d);
        while (!in_ready && g < 1000) begin
            tick();
            g++;
        end
        chk("send_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("valid_seen", int'(out_valid), 1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 200) begin
            tick();
            g++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: record accepted dividends, compare each delivered result in order.
    always @(negedge clk) begin
        exp_t e;
        int   qf;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", int'(quot), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("quot(%0d)", e.d), int'(quot), e.q);
                    chk($sformatf("rem(%0d)", e.d), int'(rem), e.r);
`ifdef DIV3_ROUND_EN
                    qf = int'(quot) - ((rem == 2'd2) ? 1 : 0);
`else
                    qf = int'(quot);
`endif
                    chk($sformatf("identity(%0d)", e.d), 3 * qf + int'(rem), e.d);
                    chk("rem_range", int'(rem <= 2'd2), 1);
                end
            end
            if (in_valid && in_ready) begin
                e.d = int'(in_data);
                e.q = model_q(e.d);
                e.r = e.d % 3;
                exp_q.push_back(e);
            end
        end
    end

    initial begin
        int n;
        int vals[5] = '{1022, 1023, 0, 1, 2};

        // Reset state
        repeat (2) tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_quot", int'(quot), 0);
        chk("rst_rem", int'(rem), 0);
        reset = 1'b0;
        tick();

        // 765: latency, single-cycle pulse, accept interval
        out_ready = 1'b1;
        send(765);
        wait_valid(n);
        chk("latency", n, IN_W);
        tick();
        chk("out_valid_pulse", int'(out_valid), 0);
        chk("in_ready_back", int'(in_ready), 1);
        drain();

        foreach (vals[i]) begin
            send(vals[i]);
            drain();
        end

        // Backpressure on dividend 100, with a competing in_valid held high
        out_ready = 1'b0;
        send(100);
        wait_valid(n);
        in_valid = 1'b1;
        in_data  = IN_W'(7);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_quot", int'(quot), 33);
            chk("bp_rem", int'(rem), 1);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);
        drain();

        // Reset four cycles into BUSY for 500, then 9
        send(500);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) n++;
        end
        chk("stale_500", n, 0);
        send(9);
        wait_valid(n);
        chk("latency_after_reset", n, IN_W);
        drain();

        // Exhaustive sweep with random input gaps and output stalls
        fork
            begin
                for (int d = 0; d < (1 << IN_W); d++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(d);
                end
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
